pll_reset_sequencer: RTL

Supervises the board PLL and generates the system reset for the logic it clocks. The block drives the PLL reset input and consumes the PLL `locked` output. It keeps the downstream system in reset until lock has been stable for a programmable time, and re-initialises the PLL on lock loss or lock timeout. It runs on the free-running 50 MHz reference clock, so it keeps operating while the PLL outputs are stopped.

---
 rtl/pll_seq_pkg.sv | 29 ++
 rtl/bit_synchronizer.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared definitions for the PLL reset sequencer: state encoding, default
//   cycle constants, event-counter saturation limit and the saturating
//   increment helper used by both event counters.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_RESET_HOLD_CYCLES   = 256;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_CNT_WIDTH           = 20;

  localparam logic [7:0] CNT_SAT = 8'd255;

  // Event counters stick at CNT_SAT instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer
//   Multi-flop synchroniser for a single asynchronous level signal.
//   Ports:
//     i_clk    destination clock
//     i_rst_n  synchronous active-low reset, clears every stage
//     i_d      asynchronous input
//     o_q      synchronised output, STAGES cycles after i_d
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises a PLL from the free-running reference clock: pulses the PLL
//   reset, waits for lock, requires lock to be stable, holds the system reset
//   for a programmable time and then releases it. Lock loss or a relock
//   request in HOLD/RUN re-initialises the PLL.
//
//   Optional feature macro: PLL_RESET_SEQ_TIMEOUT_EN
//     defined   -> WAIT_LOCK gives up after LOCK_TIMEOUT_CYCLES and retries
//                  the PLL reset; timeout_count counts those retries.
//     undefined -> WAIT_LOCK waits indefinitely; timeout_count is 0.
//
//   Ports:
//     clk            reference clock (free-running)
//     reset_n        synchronous active-low reset
//     locked_in      PLL lock, asynchronous to clk
//     force_relock   single-cycle relock request (honoured in HOLD/RUN)
//     pll_rst        active-high PLL reset
//     sys_reset      active-high system reset, low only in RUN
//     ready          high only in RUN
//     relock_count   lock losses + forced relocks, saturating at 255
//     timeout_count  lock timeouts, saturating at 255
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH           = DEF_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked_in,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  localparam logic [CNT_WIDTH-1:0] PLL_RST_LAST = CNT_WIDTH'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_pll_rst;
  logic                 r_sys_reset;
  logic                 r_ready;
  logic [7:0]           r_relock_count;
  logic                 w_locked_s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (locked_in),
    .o_q     (w_locked_s)
  );

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  logic [7:0] r_timeout_count;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= PLL_RST;
      r_cnt          <= '0;
      r_pll_rst      <= 1'b1;
      r_sys_reset    <= 1'b1;
      r_ready        <= 1'b0;
      r_relock_count <= '0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
      r_timeout_count <= '0;
`endif
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_cnt == PLL_RST_LAST) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
          else if (r_cnt == TIMEOUT_LAST) begin
            r_state         <= PLL_RST;
            r_cnt           <= '0;
            r_pll_rst       <= 1'b1;
            r_timeout_count <= sat_inc(r_timeout_count);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`else
          // No timeout: the count only stops short of wrapping.
          else if (r_cnt != TIMEOUT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        STABLE: begin
          // A lock glitch here is treated as the PLL still settling:
          // go back to waiting without resetting the PLL.
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (!w_locked_s || force_relock) begin
            r_state        <= PLL_RST;
            r_cnt          <= '0;
            r_pll_rst      <= 1'b1;
            r_relock_count <= sat_inc(r_relock_count);
          end else if (r_cnt == HOLD_LAST) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_sys_reset <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RUN: begin
          // Lock loss and relock request in the same cycle count once.
          if (!w_locked_s || force_relock) begin
            r_state        <= PLL_RST;
            r_cnt          <= '0;
            r_pll_rst      <= 1'b1;
            r_sys_reset    <= 1'b1;
            r_ready        <= 1'b0;
            r_relock_count <= sat_inc(r_relock_count);
          end
        end

        default: begin
          r_state     <= PLL_RST;
          r_cnt       <= '0;
          r_pll_rst   <= 1'b1;
          r_sys_reset <= 1'b1;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst      = r_pll_rst;
  assign sys_reset    = r_sys_reset;
  assign ready        = r_ready;
  assign relock_count = r_relock_count;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  assign timeout_count = r_timeout_count;
`else
  assign timeout_count = 8'd0;
`endif

endmodule
